// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS32 datapath: opcodes, ALU op
// classes, datapath select encodings and the main-control state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_REG = 1'b1;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  localparam logic REGDST_RT = 1'b0;
  localparam logic REGDST_RD = 1'b1;

  localparam logic MEMTOREG_ALU = 1'b0;
  localparam logic MEMTOREG_MDR = 1'b1;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return is_mem_op(op) || (op == OP_RTYPE) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS32 datapath: sequences each
// instruction over several cycles and waits on a ready-qualified memory.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t cur;
  state_t nxt;
  logic   pc_write;
  logic   branch;

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(opcode)) nxt = S_MEMADR;
        else begin
          case (opcode)
            OP_RTYPE: nxt = S_EXECUTE;
            OP_BEQ:   nxt = S_BRANCH;
            OP_ADDI:  nxt = S_ADDIEX;
            OP_J:     nxt = S_JUMP;
            default:  nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // Moore decode of the current state; everything is forced idle while in
  // reset so an abandoned instruction cannot write anything.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = IORD_PC;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    reg_dst    = REGDST_RT;
    mem_to_reg = MEMTOREG_ALU;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMMSH;
          illegal_op = !is_legal_op(opcode);
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = IORD_ALUOUT;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = MEMTOREG_MDR;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          i_or_d    = IORD_ALUOUT;
        end
        S_EXECUTE: begin
          alu_src_a = SRCA_REG;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = REGDST_RD;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_REG;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          branch    = 1'b1;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en = pc_write | (branch & zero);
  assign state = cur;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: a per-cycle model built from per-instruction
// step lists, plus literal state traces for each instruction class.
module tb_mips_mc_control;
  import mips_pkg::*;

  localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_MEMADR = 4'd2,
                         T_MEMRD = 4'd3, T_MEMWB = 4'd4, T_MEMWR = 4'd5,
                         T_EXECUTE = 4'd6, T_ALUWB = 4'd7, T_BRANCH = 4'd8,
                         T_ADDIEX = 4'd9, T_ADDIWB = 4'd10, T_JUMP = 4'd11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] step;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state;

  entry_t      q[$];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  logic [63:0] trace;
  int          traceLen;
  entry_t      cmpE;
  ctrl_t       cmpAct;

  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .state      (state)
  );

  function automatic logic legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  // Each output is derived column-wise: the set of steps that raise it.
  function automatic ctrl_t expWord(input entry_t e);
    ctrl_t      c;
    logic [3:0] s;
    c = '0;
    s = e.step;
    if (e.rst) begin
      c.mem_req    = s inside {T_FETCH, T_MEMRD, T_MEMWR};
      c.mem_write  = (s == T_MEMWR);
      c.i_or_d     = s inside {T_MEMRD, T_MEMWR};
      c.ir_write   = (s == T_FETCH) && e.rdy;
      c.pc_en      = ((s == T_FETCH) && e.rdy) || (s == T_JUMP) ||
                     ((s == T_BRANCH) && e.z);
      c.pc_src     = (s == T_BRANCH) ? 2'b01 : (s == T_JUMP) ? 2'b10 : 2'b00;
      c.alu_src_a  = s inside {T_MEMADR, T_ADDIEX, T_EXECUTE, T_BRANCH};
      c.alu_src_b  = (s == T_FETCH) ? 2'b01 : (s == T_DECODE) ? 2'b11 :
                     (s inside {T_MEMADR, T_ADDIEX}) ? 2'b10 : 2'b00;
      c.alu_op     = (s == T_EXECUTE) ? 2'b10 : (s == T_BRANCH) ? 2'b01 : 2'b00;
      c.reg_dst    = (s == T_ALUWB);
      c.mem_to_reg = (s == T_MEMWB);
      c.reg_write  = s inside {T_MEMWB, T_ALUWB, T_ADDIWB};
      c.illegal_op = (s == T_DECODE) && !legal(e.op);
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               name, cycle, act, req);
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (q.size() > 0) begin
      cmpE   = q.pop_front();
      cmpAct = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                reg_write, illegal_op};
      checkOutput("ctrl", 64'(cmpAct), 64'(expWord(cmpE)));
      checkOutput("state", 64'(state), 64'(cmpE.step));
      trace = {trace[59:0], state};
      traceLen++;
    end
  end

  task automatic pushStep(input logic rst, input logic [5:0] op, input logic z,
                          input logic rdy, input logic [3:0] step);
    entry_t e;
    e.rst  = rst;
    e.op   = op;
    e.z    = z;
    e.rdy  = rdy;
    e.step = step;
    q.push_back(e);
  endtask

  task automatic runQueue();
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        rst_n     = q[0].rst;
        opcode    = q[0].op;
        zero      = q[0].z;
        mem_ready = q[0].rdy;
      end
    end
    @(negedge clk);
    #1;
    checkOutput("queue drained", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  // fw/mw are wait cycles in FETCH and in the memory step; idle is the
  // mem_ready level driven during steps that make no memory request.
  task automatic applyStimulus(input logic [5:0] op, input logic z,
                               input int fw, input int mw, input logic idle);
    trace    = '0;
    traceLen = 0;
    for (int i = 0; i < fw; i++) pushStep(1'b1, op, z, 1'b0, T_FETCH);
    pushStep(1'b1, op, z, 1'b1, T_FETCH);
    pushStep(1'b1, op, z, idle, T_DECODE);
    if (op == OP_LW) begin
      pushStep(1'b1, op, z, idle, T_MEMADR);
      for (int i = 0; i < mw; i++) pushStep(1'b1, op, z, 1'b0, T_MEMRD);
      pushStep(1'b1, op, z, 1'b1, T_MEMRD);
      pushStep(1'b1, op, z, idle, T_MEMWB);
    end else if (op == OP_SW) begin
      pushStep(1'b1, op, z, idle, T_MEMADR);
      for (int i = 0; i < mw; i++) pushStep(1'b1, op, z, 1'b0, T_MEMWR);
      pushStep(1'b1, op, z, 1'b1, T_MEMWR);
    end else if (op == OP_RTYPE) begin
      pushStep(1'b1, op, z, idle, T_EXECUTE);
      pushStep(1'b1, op, z, idle, T_ALUWB);
    end else if (op == OP_BEQ) begin
      pushStep(1'b1, op, z, idle, T_BRANCH);
    end else if (op == OP_ADDI) begin
      pushStep(1'b1, op, z, idle, T_ADDIEX);
      pushStep(1'b1, op, z, idle, T_ADDIWB);
    end else if (op == OP_J) begin
      pushStep(1'b1, op, z, idle, T_JUMP);
    end
    runQueue();
  endtask

  task automatic applyResetMid();
    trace    = '0;
    traceLen = 0;
    pushStep(1'b1, OP_SW, 1'b0, 1'b1, T_FETCH);
    pushStep(1'b1, OP_SW, 1'b0, 1'b0, T_DECODE);
    pushStep(1'b1, OP_SW, 1'b0, 1'b0, T_MEMADR);
    pushStep(1'b1, OP_SW, 1'b0, 1'b0, T_MEMWR);
    pushStep(1'b0, OP_SW, 1'b0, 1'b0, T_MEMWR);
    pushStep(1'b0, OP_SW, 1'b0, 1'b1, T_FETCH);
    pushStep(1'b0, OP_SW, 1'b0, 1'b1, T_FETCH);
    runQueue();
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    trace     = '0;
    traceLen  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    pushStep(1'b0, 6'd0, 1'b0, 1'b1, T_FETCH);
    pushStep(1'b0, 6'd0, 1'b1, 1'b1, T_FETCH);
    runQueue();
    checkOutput("reset trace", trace, 64'h00);
    checkOutput("reset cycles", 64'(traceLen), 64'd2);

    applyStimulus(OP_RTYPE, 1'b0, 0, 0, 1'b0);
    checkOutput("rtype trace", trace, 64'h0167);
    checkOutput("rtype cycles", 64'(traceLen), 64'd4);

    applyStimulus(OP_LW, 1'b0, 0, 2, 1'b0);
    checkOutput("lw wait trace", trace, 64'h0123334);
    checkOutput("lw wait cycles", 64'(traceLen), 64'd7);

    applyStimulus(OP_BEQ, 1'b1, 0, 0, 1'b0);
    checkOutput("beq taken trace", trace, 64'h018);
    checkOutput("beq taken cycles", 64'(traceLen), 64'd3);

    applyStimulus(OP_BEQ, 1'b0, 0, 0, 1'b1);
    checkOutput("beq untaken trace", trace, 64'h018);
    checkOutput("beq untaken cycles", 64'(traceLen), 64'd3);

    applyStimulus(OP_ADDI, 1'b1, 3, 0, 1'b1);
    checkOutput("addi fetch stall trace", trace, 64'h000019A);
    checkOutput("addi fetch stall cycles", 64'(traceLen), 64'd7);

    applyStimulus(OP_SW, 1'b0, 0, 0, 1'b1);
    checkOutput("sw trace", trace, 64'h0125);
    checkOutput("sw cycles", 64'(traceLen), 64'd4);

    applyStimulus(OP_J, 1'b1, 0, 0, 1'b0);
    checkOutput("j trace", trace, 64'h01B);
    checkOutput("j cycles", 64'(traceLen), 64'd3);

    applyStimulus(6'b111111, 1'b1, 0, 0, 1'b0);
    checkOutput("illegal trace", trace, 64'h01);
    checkOutput("illegal cycles", 64'(traceLen), 64'd2);

    applyStimulus(6'b000101, 1'b0, 1, 0, 1'b1);
    checkOutput("bne illegal trace", trace, 64'h001);

    applyStimulus(OP_SW, 1'b0, 0, 3, 1'b0);
    checkOutput("sw wait trace", trace, 64'h0125555);

    applyResetMid();
    checkOutput("reset mid trace", trace, 64'h0125500);
    checkOutput("reset mid cycles", 64'(traceLen), 64'd7);

    applyStimulus(OP_RTYPE, 1'b1, 0, 0, 1'b1);
    checkOutput("rtype after reset trace", trace, 64'h0167);

    applyStimulus(OP_LW, 1'b0, 0, 0, 1'b0);
    checkOutput("lw trace", trace, 64'h01234);
    checkOutput("lw cycles", 64'(traceLen), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Main control FSM for the multicycle MIPS32 datapath. Decodes the opcode of the instruction register and sequences fetch, decode, execute, memory and write-back steps over several cycles. Drives register/memory write enables and datapath mux selects, and supplies the 2-bit `alu_op` consumed by `alu_control`. Memory accesses use a request/ready handshake, so the FSM tolerates variable-latency memory.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `opcode` input 6: `instr[31:26]` from the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_req` output 1: memory access request.
- `mem_write` output 1: store request qualifier.
- `i_or_d` output 1: address mux select, 0 = PC, 1 = ALUOut.
- `ir_write` output 1: instruction register load.
- `pc_en` output 1: PC load, equal to `pc_write | (branch & zero)`.
- `pc_src` output 2: next-PC select, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` output 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `mem_to_reg` output 1: 0 = ALUOut, 1 = memory data register.
- `reg_write` output 1: register file write.
- `illegal_op` output 1: one-cycle pulse on an unsupported opcode.
- `state` output 4: current state, for debug.

## Operation
- Opcodes decoded: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Codes 12–15 are unreachable; if entered, next state is FETCH and all enables are 0.
- Transitions:
  - FETCH goes to DECODE when `mem_ready`, otherwise holds.
  - DECODE branches on opcode: lw or sw → MEMADR; R-type → EXECUTE; beq → BRANCH; addi → ADDIEX; j → JUMP.
  - DECODE with any other opcode pulses `illegal_op` and goes to FETCH.
  - MEMADR goes to MEMRD for lw and MEMWR for sw.
  - MEMRD goes to MEMWB when `mem_ready`, otherwise holds.
  - MEMWR goes to FETCH when `mem_ready`, otherwise holds.
  - EXECUTE → ALUWB; ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all return to FETCH.
- Outputs are Moore-decoded from `state`, except the FETCH enables, which are gated by `mem_ready`. Any signal not listed for a state is 0.
  - FETCH: `mem_req`=1, `alu_src_b`=01. `ir_write`=`pc_write`=`mem_ready`.
  - DECODE: `alu_src_b`=11 (precomputes the branch target).
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10.
  - MEMRD: `mem_req`=1, `i_or_d`=1.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1.
  - MEMWR: `mem_req`=1, `mem_write`=1, `i_or_d`=1.
  - EXECUTE: `alu_src_a`=1, `alu_op`=10.
  - ALUWB: `reg_write`=1, `reg_dst`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1.
  - ADDIWB: `reg_write`=1.
  - JUMP: `pc_src`=10, `pc_write`=1.
- `mem_write` and `i_or_d` stay stable for the whole time MEMWR is stalled.

## Timing
- Reset: when `rst_n`=0 at a rising edge, state becomes FETCH.
  - While `rst_n`=0, every enable and request output is 0 (`mem_req`, `mem_write`, `ir_write`, `pc_en`, `reg_write`, `illegal_op`).
  - While `rst_n`=0, every select output is 0.
  - Reset asserted mid-instruction abandons that instruction; no write enable fires in the reset cycle.
- Cycles per instruction with zero-wait memory (`mem_ready` high whenever `mem_req` is high):
  - beq and j: 3.
  - R-type, sw and addi: 4.
  - lw: 5.
- Each wait cycle adds exactly one cycle.
- Taken branch: `pc_en` is high in the BRANCH cycle only when `zero`=1.
- `illegal_op` is high for exactly the one DECODE cycle; the next cycle is FETCH.

## Structure
- Shared package `mips_pkg` holds:
  - opcode localparams (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`);
  - `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`;
  - `state_t`, a 4-bit enum;
  - the select-encoding constants.
- `alu_control` imports the same `ALUOP_*` constants.
- No sub-module. Use one state register, one combinational next-state block and one output-decode block.

## Test plan
- Reset, then zero-wait R-type (opcode 0): state sequence 0,1,6,7,0; `alu_op`=10 in EXECUTE; `reg_write`=1 and `reg_dst`=1 in ALUWB only.
- lw with `mem_ready` low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0; `mem_req`=1 and `i_or_d`=1 for all three MEMRD cycles; `reg_write`=1 and `mem_to_reg`=1 in MEMWB.
- beq with `zero`=1: `pc_en`=1 and `pc_src`=01 in BRANCH. Repeat with `zero`=0: `pc_en`=0. Both take 3 cycles.
- FETCH held with `mem_ready`=0 for 3 cycles: `ir_write`=0 and `pc_en`=0 while stalled; both are 1 in the ready cycle.
- Opcode 111111: `illegal_op` pulses once in DECODE; no `reg_write`, `mem_write` or `pc_en` fires; next state is FETCH.
- `rst_n` dropped during MEMWR: `mem_write`=0 immediately; state=FETCH after the edge and stays there until `rst_n`=1.
